sdram_arbiter: RTL and testbench

Two-master arbiter that shares the single SoC-side command port of sdram_controller between master 0 (CPU) and master 1 (DMA/video).
- Serialises requests with round-robin priority.
- Registers each accepted command and issues it as a one-cycle strobe.
- Routes the completion pulse and read data back to the owning master.
- Provides a watchdog against a hung controller.

---
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-master round-robin arbiter in front of the sdram_controller command port
//
// Ports:
//   clk, reset_port                  clock, asynchronous active-high reset
//   mN_req/we/addr/wr_data/wr_mask   master N command (N = 0 CPU, 1 DMA/video), req held until ack
//   mN_ack_port                      one-cycle pulse, command accepted and issued
//   mN_done_port                     one-cycle pulse, command completed or timed out
//   mN_rd_data_port                  read data, updated with done of a read, held otherwise
//   timeout_err_port                 sticky watchdog expiry flag
//   ctrl_busy/ready/rd_data          controller status and read return
//   ctrl_addr/wr_data/wr_mask        registered command fields, held between commands
//   ctrl_wr_en/rd_en                 one-cycle command strobes
module sdram_arbiter #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_port,
  input  logic                  m0_req_port,
  input  logic                  m0_we_port,
  input  logic [ADDR_WIDTH-1:0] m0_addr_port,
  input  logic [DATA_WIDTH-1:0] m0_wr_data_port,
  input  logic [MASK_WIDTH-1:0] m0_wr_mask_port,
  output logic                  m0_ack_port,
  output logic                  m0_done_port,
  output logic [DATA_WIDTH-1:0] m0_rd_data_port,
  input  logic                  m1_req_port,
  input  logic                  m1_we_port,
  input  logic [ADDR_WIDTH-1:0] m1_addr_port,
  input  logic [DATA_WIDTH-1:0] m1_wr_data_port,
  input  logic [MASK_WIDTH-1:0] m1_wr_mask_port,
  output logic                  m1_ack_port,
  output logic                  m1_done_port,
  output logic [DATA_WIDTH-1:0] m1_rd_data_port,
  output logic                  timeout_err_port,
  input  logic                  ctrl_busy_port,
  input  logic                  ctrl_ready_port,
  input  logic [DATA_WIDTH-1:0] ctrl_rd_data_port,
  output logic [ADDR_WIDTH-1:0] ctrl_addr_port,
  output logic [DATA_WIDTH-1:0] ctrl_wr_data_port,
  output logic [MASK_WIDTH-1:0] ctrl_wr_mask_port,
  output logic                  ctrl_wr_en_port,
  output logic                  ctrl_rd_en_port
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter is compared one step early so that done lands on the
  // cycle in which the count reaches TIMEOUT_CYCLES-1.
  localparam int WD_FIRE = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t          state, state_next;
  logic            owner;
  logic            last_grant;
  logic            we_r;
  logic [1:0]      done_r;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;
  logic            grant_valid;
  logic            grant_id;

  // Sole requester wins; on a tie the master not granted last wins.
  always_comb begin
    grant_valid = (m0_req_port | m1_req_port) & ~ctrl_busy_port;
    if (m0_req_port && m1_req_port) grant_id = ~last_grant;
    else                            grant_id = m1_req_port;
  end

  assign wd_fire = (TIMEOUT_CYCLES > 0) && (wd_cnt == WD_W'(WD_FIRE));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (grant_valid) state_next = ISSUE;
      ISSUE:     state_next = WAIT_DONE;
      WAIT_DONE: if (ctrl_ready_port || wd_fire) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_port) begin
    if (reset_port) begin
      state             <= IDLE;
      owner             <= 1'b0;
      last_grant        <= 1'b1;  // so m0 wins the first tie
      we_r              <= 1'b0;
      done_r            <= 2'b00;
      wd_cnt            <= '0;
      ctrl_addr_port    <= '0;
      ctrl_wr_data_port <= '0;
      ctrl_wr_mask_port <= '0;
      m0_rd_data_port   <= '0;
      m1_rd_data_port   <= '0;
      timeout_err_port  <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= 2'b00;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_id;
            last_grant <= grant_id;
            if (grant_id) begin
              we_r              <= m1_we_port;
              ctrl_addr_port    <= m1_addr_port;
              ctrl_wr_data_port <= m1_wr_data_port;
              ctrl_wr_mask_port <= m1_wr_mask_port;
            end else begin
              we_r              <= m0_we_port;
              ctrl_addr_port    <= m0_addr_port;
              ctrl_wr_data_port <= m0_wr_data_port;
              ctrl_wr_mask_port <= m0_wr_mask_port;
            end
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT_DONE: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          // A completion arriving on the expiry cycle wins over the timeout.
          if (ctrl_ready_port) begin
            done_r <= owner ? 2'b10 : 2'b01;
            if (!we_r) begin
              if (owner) m1_rd_data_port <= ctrl_rd_data_port;
              else       m0_rd_data_port <= ctrl_rd_data_port;
            end
          end else if (wd_fire) begin
            done_r           <= owner ? 2'b10 : 2'b01;
            timeout_err_port <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ctrl_wr_en_port = (state == ISSUE) &  we_r;
  assign ctrl_rd_en_port = (state == ISSUE) & ~we_r;
  assign m0_ack_port     = (state == ISSUE) & ~owner;
  assign m1_ack_port     = (state == ISSUE) &  owner;
  assign m0_done_port    = done_r[0];
  assign m1_done_port    = done_r[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard testbench for sdram_arbiter
module tb_sdram_arbiter;

  typedef struct {
    logic        owner;
    logic        we;
    logic [22:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } cmd_t;

  typedef struct {
    logic        owner;
    logic [31:0] rd;
    logic        terr;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [22:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [3:0]  m0_mask = '0;
  logic        m0_ack, m0_done;
  logic [31:0] m0_rd;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [22:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [3:0]  m1_mask = '0;
  logic        m1_ack, m1_done;
  logic [31:0] m1_rd;
  logic        terr;
  logic        ctrl_busy;
  logic        ctrl_ready = 1'b0;
  logic [31:0] ctrl_rd_data = '0;
  logic [22:0] ctrl_addr;
  logic [31:0] ctrl_wdata;
  logic [3:0]  ctrl_mask;
  logic        ctrl_wr_en, ctrl_rd_en;

  bit          model_force_busy = 1'b0;
  bit          model_pending = 1'b0;
  bit          model_hang = 1'b0;
  bit          model_inject = 1'b0;
  int          model_lat = 2;
  int          model_cnt = 0;
  logic [31:0] model_rd = '0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  cmd_t  exp_cmd[$];
  done_t exp_done[$];

  assign ctrl_busy = model_force_busy | model_pending;

  sdram_arbiter #(
    .ADDR_WIDTH(23), .DATA_WIDTH(32), .MASK_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_port(rst),
    .m0_req_port(m0_req), .m0_we_port(m0_we), .m0_addr_port(m0_addr),
    .m0_wr_data_port(m0_wdata), .m0_wr_mask_port(m0_mask),
    .m0_ack_port(m0_ack), .m0_done_port(m0_done), .m0_rd_data_port(m0_rd),
    .m1_req_port(m1_req), .m1_we_port(m1_we), .m1_addr_port(m1_addr),
    .m1_wr_data_port(m1_wdata), .m1_wr_mask_port(m1_mask),
    .m1_ack_port(m1_ack), .m1_done_port(m1_done), .m1_rd_data_port(m1_rd),
    .timeout_err_port(terr),
    .ctrl_busy_port(ctrl_busy), .ctrl_ready_port(ctrl_ready), .ctrl_rd_data_port(ctrl_rd_data),
    .ctrl_addr_port(ctrl_addr), .ctrl_wr_data_port(ctrl_wdata), .ctrl_wr_mask_port(ctrl_mask),
    .ctrl_wr_en_port(ctrl_wr_en), .ctrl_rd_en_port(ctrl_rd_en)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Controller model: busy from strobe until ready, ready after model_lat cycles.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_pending = 1'b0;
      ctrl_ready = 1'b0;
    end else begin
      ctrl_ready = 1'b0;
      if (ctrl_wr_en || ctrl_rd_en) begin
        model_pending = 1'b1;
        model_cnt = model_lat;
      end else if (model_pending && !model_hang) begin
        model_cnt--;
        if (model_cnt <= 0) begin
          ctrl_ready = 1'b1;
          ctrl_rd_data = model_rd;
          model_pending = 1'b0;
        end
      end
      if (model_inject) begin
        ctrl_ready = 1'b1;
        ctrl_rd_data = 32'h7777_7777;
        model_inject = 1'b0;
      end
    end
  end

  // Monitor: pops expected commands on strobes and expected completions on dones.
  initial forever begin
    cmd_t  c;
    done_t d;
    @(negedge clk);
    if (!rst) begin
      if (ctrl_wr_en || ctrl_rd_en) begin
        check("strobe_excl", 64'(ctrl_wr_en & ctrl_rd_en), 0);
        if (exp_cmd.size() == 0) check("cmd_unexpected", 64'({ctrl_wr_en, ctrl_rd_en}), 0);
        else begin
          c = exp_cmd.pop_front();
          check("ack_owner", 64'({m1_ack, m0_ack}), c.owner ? 2'b10 : 2'b01);
          check("cmd_wr_en", 64'(ctrl_wr_en), 64'(c.we));
          check("cmd_addr", 64'(ctrl_addr), 64'(c.addr));
          if (c.we) check("cmd_wdata", 64'(ctrl_wdata), 64'(c.data));
          check("cmd_mask", 64'(ctrl_mask), 64'(c.mask));
        end
      end else if (m0_ack || m1_ack) begin
        check("ack_no_strobe", 64'({m1_ack, m0_ack}), 0);
      end
      if (m0_done || m1_done) begin
        check("done_excl", 64'(m0_done & m1_done), 0);
        if (exp_done.size() == 0) check("done_unexpected", 64'({m1_done, m0_done}), 0);
        else begin
          d = exp_done.pop_front();
          check("done_owner", 64'({m1_done, m0_done}), d.owner ? 2'b10 : 2'b01);
          check("done_rd_data", 64'(d.owner ? m1_rd : m0_rd), 64'(d.rd));
          check("done_terr", 64'(terr), 64'(d.terr));
        end
      end
    end
  end

  task automatic drive_m(input bit m, input bit we, input logic [22:0] a,
                         input logic [31:0] dt, input logic [3:0] k);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = dt; m1_mask = k;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = dt; m0_mask = k;
    end
  endtask

  task automatic exp_c(input bit m, input bit we, input logic [22:0] a,
                       input logic [31:0] dt, input logic [3:0] k);
    exp_cmd.push_back('{m, we, a, dt, k});
  endtask

  task automatic exp_d(input bit m, input logic [31:0] rd, input bit te);
    exp_done.push_back('{m, rd, te});
  endtask

  // which: 0 m0_ack, 1 m1_ack, 2 any done, 3 any strobe
  task automatic wait_ev(input int which, input string name, output int c);
    bit hit;
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = m0_ack;
        1:       hit = m1_ack;
        2:       hit = m0_done | m1_done;
        default: hit = ctrl_wr_en | ctrl_rd_en;
      endcase
      if (hit) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_checks++;
      $display("FAIL %s: event not seen within 400 cycles", name);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_done.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, 64'(exp_done.size()), 0);
  endtask

  initial begin
    int t0, ca, cd, n, held;
    repeat (3) @(negedge clk);
    check("rst_strobes", 64'({ctrl_wr_en, ctrl_rd_en, m0_ack, m1_ack, m0_done, m1_done}), 0);
    check("rst_rd_data", 64'({m0_rd, m1_rd}), 0);
    check("rst_ctrl_fields", 64'({ctrl_addr, ctrl_mask, terr}), 0);
    check("rst_ctrl_wdata", 64'(ctrl_wdata), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single read on m0
    model_lat = 5; model_rd = 32'hDEAD_BEEF;
    exp_c(0, 0, 23'h12345, 0, 4'h0); exp_d(0, 32'hDEAD_BEEF, 0);
    drive_m(0, 0, 23'h12345, 0, 4'h0);
    t0 = cyc;
    wait_ev(0, "t1_ack", ca);
    m0_req = 1'b0;
    check("t1_ack_latency", 64'(ca - t0), 1);
    wait_ev(2, "t1_done", cd);
    check("t1_done_latency", 64'(cd - ca), 6);
    drain("t1_drain");

    // m1 write then read; the write completion carries junk read data
    model_lat = 3; model_rd = 32'hBAD0_BAD0;
    exp_c(1, 1, 23'h300, 32'h55AA_1234, 4'hF); exp_d(1, 32'h0, 0);
    drive_m(1, 1, 23'h300, 32'h55AA_1234, 4'hF);
    wait_ev(1, "t4w_ack", ca);
    m1_req = 1'b0;
    drain("t4w_drain");
    model_rd = 32'h55AA_1234;
    exp_c(1, 0, 23'h300, 0, 4'hF); exp_d(1, 32'h55AA_1234, 0);
    drive_m(1, 0, 23'h300, 0, 4'hF);
    wait_ev(1, "t4r_ack", ca);
    m1_req = 1'b0;
    drain("t4r_drain");

    // contention: last grant was m1, so m0 leads and grants alternate
    model_lat = 2; model_rd = 32'hFFFF_0000;
    exp_c(0, 1, 23'h100, 32'hA5A5_A5A5, 4'b0011);
    exp_c(1, 1, 23'h200, 32'h5A5A_5A5A, 4'b1100);
    exp_c(0, 1, 23'h100, 32'hA5A5_A5A5, 4'b0011);
    exp_c(1, 1, 23'h200, 32'h5A5A_5A5A, 4'b1100);
    exp_d(0, 32'hDEAD_BEEF, 0); exp_d(1, 32'h55AA_1234, 0);
    exp_d(0, 32'hDEAD_BEEF, 0); exp_d(1, 32'h55AA_1234, 0);
    drive_m(0, 1, 23'h100, 32'hA5A5_A5A5, 4'b0011);
    drive_m(1, 1, 23'h200, 32'h5A5A_5A5A, 4'b1100);
    n = 0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("t2_ack_count", 64'(n), 4);
    drain("t2_drain");

    // busy hold for 200 cycles, strobe one cycle after busy falls
    model_force_busy = 1'b1; model_rd = 32'h0BAD_F00D;
    exp_c(1, 0, 23'h400, 0, 4'h5); exp_d(1, 32'h0BAD_F00D, 0);
    drive_m(1, 0, 23'h400, 0, 4'h5);
    held = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ctrl_wr_en || ctrl_rd_en) held++;
    end
    check("t3_no_strobe_while_busy", 64'(held), 0);
    model_force_busy = 1'b0;
    t0 = cyc;
    wait_ev(3, "t3_strobe", ca);
    m1_req = 1'b0;
    check("t3_strobe_latency", 64'(ca - t0), 1);
    drain("t3_drain");

    // watchdog: no ready, done 16 cycles after strobe, sticky error
    model_hang = 1'b1;
    exp_c(0, 0, 23'h500, 0, 4'h0); exp_d(0, 32'hDEAD_BEEF, 1);
    drive_m(0, 0, 23'h500, 0, 4'h0);
    wait_ev(0, "t5_ack", ca);
    m0_req = 1'b0;
    wait_ev(2, "t5_done", cd);
    check("t5_timeout_latency", 64'(cd - ca), 16);
    model_hang = 1'b0; model_pending = 1'b0;
    drain("t5_drain");
    model_inject = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_terr_sticky", 64'(terr), 1);
    check("t5_late_ready_ignored", 64'(m0_rd), 64'(32'hDEAD_BEEF));
    model_lat = 2; model_rd = 32'h600D_CAFE;
    exp_c(0, 0, 23'h600, 0, 4'h0); exp_d(0, 32'h600D_CAFE, 1);
    drive_m(0, 0, 23'h600, 0, 4'h0);
    wait_ev(0, "t5n_ack", ca);
    m0_req = 1'b0;
    drain("t5n_drain");

    // reset while waiting for completion
    model_lat = 20;
    exp_c(1, 1, 23'h700, 32'h1234_5678, 4'hF);
    drive_m(1, 1, 23'h700, 32'h1234_5678, 4'hF);
    wait_ev(1, "t6_ack", ca);
    m1_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_strobes", 64'({ctrl_wr_en, ctrl_rd_en, m0_ack, m1_ack, m0_done, m1_done}), 0);
    check("t6_rst_rd_data", 64'({m0_rd, m1_rd}), 0);
    check("t6_rst_fields", 64'({ctrl_addr, ctrl_mask, terr}), 0);
    model_pending = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_inject = 1'b1;
    repeat (3) @(negedge clk);
    model_lat = 2; model_rd = 32'h1357_2468;
    exp_c(0, 0, 23'h800, 0, 4'h0); exp_c(1, 0, 23'h900, 0, 4'h0);
    exp_d(0, 32'h1357_2468, 0); exp_d(1, 32'h1357_2468, 0);
    drive_m(0, 0, 23'h800, 0, 4'h0);
    drive_m(1, 0, 23'h900, 0, 4'h0);
    for (int i = 0; i < 300 && (m0_req || m1_req); i++) begin
      @(negedge clk);
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
    end
    drain("t6_drain");
    check("cmd_queue_empty", 64'(exp_cmd.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
